fetch_unit: RTL and testbench

Instruction-fetch stage of the Filter-GPU pipeline, directly upstream of decode and driven by the hazard unit's StallF/StallD/FlushD. It owns the program counter and issues requests to instruction memory over a ready handshake. It parks a completed word during a stall, and redirects on taken branches or PC writes. It also drives the IF/ID pipeline register (InstrD, PCPlus8D, ValidD) that feeds decode and RA1D/RA2D generation.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit_if_id_reg.sv | 45 ++++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM encoding
//   NOP_INSTR     : instruction word used for pipeline bubbles
//   PC_STEP       : sequential PC increment
//   PC_R15_OFFSET : offset from an instruction's PC to its R15 read value
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int NOP_INSTR     = 0;
  localparam int PC_STEP       = 4;
  localparam int PC_R15_OFFSET = 8;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register. Priority: flush > stall (hold) > load.
//   A load without a valid word inserts a bubble (NOP, valid low).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall, flush    : hold / bubble controls from the hazard unit
//   load_valid      : a real instruction is offered this cycle
//   load_instr      : offered instruction word
//   load_pc_plus8   : PC of the offered word + 8
//   instr, pc_plus8, valid : registered decode-stage outputs
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_pc_plus8,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic              valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= DATA_W'(NOP_INSTR);
      pc_plus8 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= DATA_W'(NOP_INSTR);
      pc_plus8 <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      instr    <= load_valid ? load_instr : DATA_W'(NOP_INSTR);
      pc_plus8 <= load_pc_plus8;
      valid    <= load_valid;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage: owns PCF, requests words from instruction
//   memory over a req/ready handshake, parks a completed word while the
//   front end is stalled, redirects on taken branches / PC writes and
//   drives the IF/ID register feeding decode.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   StallF, StallD, FlushD   : hazard unit controls
//   RedirectE, RedirectTarget: redirect request and new PC
//   imem_req, imem_addr      : fetch request and address (= PCF)
//   imem_ready, imem_rdata   : completion strobe and fetched word
//   InstrD, PCPlus8D, ValidD : IF/ID register outputs
//
// state | meaning
// FETCH | request at PCF; completion loads IF/ID or parks the word
// WAIT  | request outstanding at PCF, address held until ready
// HOLD  | word parked in the hold buffer while StallF, no request
// DRAIN | redirect arrived with a request outstanding; the old address
//       | is held until its word returns and is dropped, then the
//       | pending target becomes PCF
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              RedirectE,
  input  logic [ADDR_W-1:0] RedirectTarget,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] InstrD,
  output logic [ADDR_W-1:0] PCPlus8D,
  output logic              ValidD
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pcf, pcf_n;
  logic [ADDR_W-1:0] pend_pc, pend_pc_n;
  logic [DATA_W-1:0] hold_word, hold_word_n;
  logic              hold_valid, hold_valid_n;

  logic              req_fsm;
  logic              done;
  logic              load_valid;
  logic [DATA_W-1:0] load_instr;
  logic [ADDR_W-1:0] drain_target;

  // No request is presented while reset is held; it rises with the first
  // cycle after release.
  assign imem_req  = req_fsm & ~rst;
  assign imem_addr = pcf;
  assign done      = imem_req & imem_ready;

  // A redirect seen during DRAIN replaces the pending target.
  assign drain_target = RedirectE ? RedirectTarget : pend_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pcf        <= RESET_PC;
      pend_pc    <= RESET_PC;
      hold_word  <= DATA_W'(NOP_INSTR);
      hold_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      pend_pc    <= pend_pc_n;
      hold_word  <= hold_word_n;
      hold_valid <= hold_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pcf_n        = pcf;
    pend_pc_n    = pend_pc;
    hold_word_n  = hold_word;
    hold_valid_n = hold_valid;
    req_fsm      = 1'b1;
    load_valid   = 1'b0;
    load_instr   = imem_rdata;

    case (state)
      FETCH, WAIT: begin
        if (RedirectE) begin
          hold_valid_n = 1'b0;
          // A word completing in the redirect cycle is dropped. Only a
          // request still outstanding has to be drained before the
          // address may change.
          if (done) begin
            pcf_n   = RedirectTarget;
            state_n = FETCH;
          end else begin
            pend_pc_n = RedirectTarget;
            state_n   = DRAIN;
          end
        end else if (done) begin
          if (StallF) begin
            hold_word_n  = imem_rdata;
            hold_valid_n = 1'b1;
            state_n      = HOLD;
          end else begin
            load_valid = 1'b1;
            pcf_n      = pcf + ADDR_W'(PC_STEP);
            state_n    = FETCH;
          end
        end else begin
          state_n = WAIT;
        end
      end

      HOLD: begin
        req_fsm = 1'b0;
        if (RedirectE) begin
          pcf_n        = RedirectTarget;
          hold_valid_n = 1'b0;
          state_n      = FETCH;
        end else if (!StallF) begin
          load_valid   = hold_valid;
          load_instr   = hold_word;
          pcf_n        = pcf + ADDR_W'(PC_STEP);
          hold_valid_n = 1'b0;
          state_n      = FETCH;
        end
      end

      DRAIN: begin
        pend_pc_n    = drain_target;
        hold_valid_n = 1'b0;
        if (done) begin
          pcf_n   = drain_target;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

  if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (StallD),
    .flush        (FlushD),
    .load_valid   (load_valid),
    .load_instr   (load_instr),
    .load_pc_plus8(pcf + ADDR_W'(PC_R15_OFFSET)),
    .instr        (InstrD),
    .pc_plus8     (PCPlus8D),
    .valid        (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit. Instruction memory returns
//   {16'hC0DE, addr[15:0]} for every address, so expected words are
//   written out by hand below.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        RedirectE;
  logic [31:0] RedirectTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;

  int n_tests;
  int n_fail;
  int fetch12_cnt;
  int leak20_cnt;

  fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .RedirectE     (RedirectE),
    .RedirectTarget(RedirectTarget),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .InstrD        (InstrD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD)
  );

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completions at address 12 (must happen exactly once: no re-fetch).
  always @(posedge clk) begin
    if (!rst && imem_req && imem_ready && imem_addr == 32'd12)
      fetch12_cnt++;
  end

  // The redirected-away word at 20 must never appear as a valid instruction.
  always @(negedge clk) begin
    if (ValidD && InstrD == 32'hC0DE_0014)
      leak20_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc8, input logic vld);
    check_val({tag, "_instr"}, InstrD, instr);
    check_val({tag, "_pc8"}, PCPlus8D, pc8);
    check_val({tag, "_valid"}, ValidD, vld);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    fetch12_cnt    = 0;
    leak20_cnt     = 0;
    rst            = 1'b1;
    StallF         = 1'b0;
    StallD         = 1'b0;
    FlushD         = 1'b0;
    RedirectE      = 1'b0;
    RedirectTarget = 32'h0;
    imem_ready     = 1'b1;

    // Reset state
    step();
    step();
    check_val("rst_req", imem_req, 1'b0);
    check_id("rst", 32'h0, 32'h0, 1'b0);
    check_val("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    check_val("post_rst_req", imem_req, 1'b1);
    check_val("post_rst_addr", imem_addr, 32'h0);

    // Zero-wait streaming
    step();
    check_val("seq_addr4", imem_addr, 32'd4);
    check_id("seq0", 32'hC0DE_0000, 32'd8, 1'b1);
    step();
    check_val("seq_addr8", imem_addr, 32'd8);
    check_id("seq4", 32'hC0DE_0004, 32'd12, 1'b1);

    // Two wait cycles at address 8
    imem_ready = 1'b0;
    step();
    check_val("wait1_addr", imem_addr, 32'd8);
    check_val("wait1_req", imem_req, 1'b1);
    check_val("wait1_valid", ValidD, 1'b0);
    step();
    check_val("wait2_addr", imem_addr, 32'd8);
    check_val("wait2_valid", ValidD, 1'b0);
    imem_ready = 1'b1;
    step();
    check_val("wait_done_addr", imem_addr, 32'd12);
    check_id("wait8", 32'hC0DE_0008, 32'd16, 1'b1);

    // Stall three cycles while the word at 12 completes
    StallF = 1'b1;
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_req", imem_req, 1'b0);
      check_id("stall", 32'hC0DE_0008, 32'd16, 1'b1);
    end
    StallF = 1'b0;
    StallD = 1'b0;
    step();
    check_id("release12", 32'hC0DE_000C, 32'd20, 1'b1);
    check_val("release_req", imem_req, 1'b1);
    check_val("release_addr", imem_addr, 32'd16);

    // Redirect to 0x100 while waiting at 20
    step();
    check_val("pre_redir_addr", imem_addr, 32'd20);
    check_id("seq16", 32'hC0DE_0010, 32'd24, 1'b1);
    imem_ready = 1'b0;
    step();
    check_val("wait20_addr", imem_addr, 32'd20);
    RedirectE      = 1'b1;
    RedirectTarget = 32'h100;
    step();
    RedirectE = 1'b0;
    check_val("drain_addr", imem_addr, 32'd20);
    check_val("drain_req", imem_req, 1'b1);
    check_val("drain_valid", ValidD, 1'b0);
    imem_ready = 1'b1;
    step();
    check_val("redir_addr", imem_addr, 32'h100);
    check_val("drained_valid", ValidD, 1'b0);
    step();
    check_val("redir_next_addr", imem_addr, 32'h104);
    check_id("tgt100", 32'hC0DE_0100, 32'h108, 1'b1);

    // Flush wins over stall
    FlushD = 1'b1;
    StallD = 1'b1;
    step();
    FlushD = 1'b0;
    StallD = 1'b0;
    check_id("flush", 32'h0, 32'h0, 1'b0);

    // Redirect to the top of the address space, zero-wait
    check_val("pre_wrap_addr", imem_addr, 32'h108);
    RedirectE      = 1'b1;
    RedirectTarget = 32'hFFFF_FFFC;
    step();
    RedirectE = 1'b0;
    check_val("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    check_val("wrap_bubble", ValidD, 1'b0);
    step();
    check_val("wrap_addr1", imem_addr, 32'h0);
    check_id("wrapFFC", 32'hC0DE_FFFC, 32'h4, 1'b1);
    step();
    check_val("wrap_addr2", imem_addr, 32'h4);
    check_id("wrap0", 32'hC0DE_0000, 32'h8, 1'b1);

    // Asynchronous reset in the middle of an outstanding request
    imem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_addr", imem_addr, 32'h0);
    check_val("arst_req", imem_req, 1'b0);
    check_id("arst", 32'h0, 32'h0, 1'b0);
    step();
    rst        = 1'b0;
    imem_ready = 1'b1;
    #1;
    check_val("arst_rel_req", imem_req, 1'b1);
    step();
    check_val("arst_rel_addr", imem_addr, 32'h4);
    check_id("arst0", 32'hC0DE_0000, 32'h8, 1'b1);

    check_val("no_refetch12", fetch12_cnt, 1);
    check_val("no_leak20", leak20_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
